// File: rtl/uart_mem_loader_pkg.sv
// Shared types and constants for the UART memory loader.
// Bit timing is derived from the clock and baud rate.
package loader_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam int unsigned BYTES_PER_WORD = 2;

  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    return clk_hz / baud;
  endfunction

  function automatic int unsigned half_bit(input int unsigned clk_hz,
                                           input int unsigned baud);
    return clks_per_bit(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-flop synchroniser, start-bit glitch rejection,
// one-cycle byte_valid_o / frame_err_o pulses.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned HALF         = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);

  logic             sync1_q;
  logic             sync2_q;
  rx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             valid_q;
  logic             ferr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (!sync2_q) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          // Mid-start-bit resample; a high line here was a glitch
          if (cnt_q == CNT_HALF) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (sync2_q) valid_q <= 1'b1;
            else         ferr_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign byte_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: rtl/uart_mem_loader.sv
// Loads a 2^ADDR_W x 16 RAM image received over UART (high byte first).
// Define LOADER_CHECKSUM_EN to enable the running mod-2^16 checksum output.
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic        clk_100,
  input  logic        rst,
  input  logic        load_en,
  input  logic        rx,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        loading,
  output logic        done,
  output logic        frame_err,
  output logic [15:0] checksum
);

  localparam int unsigned BYTE_W  = DATA_W / BYTES_PER_WORD;
  localparam int unsigned PHASE_W = $clog2(BYTES_PER_WORD);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(BYTES_PER_WORD - 1);
  localparam logic [ADDR_W-1:0]  ADDR_LAST  = '1;

  logic [7:0]         rx_byte;
  logic               rx_valid;
  logic               rx_ferr;

  logic               load_en_q;
  logic               le_rise;
  logic               le_fall;
  logic [PHASE_W-1:0] phase_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [BYTE_W-1:0]  hi_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               mem_we_q;
  logic               loading_q;
  logic               done_q;
  logic               ferr_q;

  uart_rx_byte #(
    .CLKS_PER_BIT (clks_per_bit(CLK_HZ, BAUD)),
    .HALF         (half_bit(CLK_HZ, BAUD))
  ) u_rx (
    .clk_i        (clk_100),
    .rst_ni       (rst),
    .rx_i         (rx),
    .byte_o       (rx_byte),
    .byte_valid_o (rx_valid),
    .frame_err_o  (rx_ferr)
  );

  assign le_rise = load_en & ~load_en_q;
  assign le_fall = ~load_en & load_en_q;

  // Later assignments take priority: abort, then session start
  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      load_en_q <= 1'b0;
      phase_q   <= '0;
      addr_q    <= '0;
      hi_q      <= '0;
      wdata_q   <= '0;
      mem_we_q  <= 1'b0;
      loading_q <= 1'b0;
      done_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      load_en_q <= load_en;
      mem_we_q  <= 1'b0;
      if (mem_we_q) begin
        if (addr_q == ADDR_LAST) begin
          done_q    <= 1'b1;
          loading_q <= 1'b0;
        end else begin
          addr_q <= addr_q + ADDR_W'(1);
        end
      end
      if (rx_valid && loading_q && !le_fall) begin
        if (phase_q == PHASE_LAST) begin
          wdata_q  <= {hi_q, rx_byte};
          mem_we_q <= 1'b1;
          phase_q  <= '0;
        end else begin
          hi_q    <= rx_byte;
          phase_q <= phase_q + PHASE_W'(1);
        end
      end
      if (rx_ferr && loading_q) ferr_q <= 1'b1;
      if (le_fall && loading_q) begin
        loading_q <= 1'b0;
        phase_q   <= '0;
      end
      if (le_rise) begin
        addr_q    <= '0;
        phase_q   <= '0;
        done_q    <= 1'b0;
        ferr_q    <= 1'b0;
        loading_q <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] cks_q;

  always_ff @(posedge clk_100 or negedge rst) begin
    if (!rst) begin
      cks_q <= '0;
    end else if (le_rise) begin
      cks_q <= '0;
    end else if (mem_we_q) begin
      cks_q <= cks_q + wdata_q;
    end
  end

  assign checksum = cks_q;
`else
  assign checksum = '0;
`endif

  assign mem_we    = mem_we_q;
  assign mem_addr  = 16'(addr_q);
  assign mem_wdata = wdata_q;
  assign loading   = loading_q;
  assign done      = done_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboard bench for uart_mem_loader with a 4-word RAM and 16 clocks/bit.
module tb_uart_mem_loader;

  localparam int unsigned CPB = 16;

  logic        clk_100 = 1'b0;
  logic        rst     = 1'b0;
  logic        load_en = 1'b0;
  logic        rx      = 1'b1;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        loading;
  logic        done;
  logic        frame_err;
  logic [15:0] checksum;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    bit          last;
  } wr_t;

  wr_t         sb_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [15:0] sum_model = '0;

  uart_mem_loader #(
    .CLK_HZ (16000000),
    .BAUD   (1000000),
    .ADDR_W (2),
    .DATA_W (16)
  ) dut (
    .clk_100   (clk_100),
    .rst       (rst),
    .load_en   (load_en),
    .rx        (rx),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .loading   (loading),
    .done      (done),
    .frame_err (frame_err),
    .checksum  (checksum)
  );

  always #5 clk_100 = ~clk_100;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk_100);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = stop;
    wait_clks(CPB);
    rx = 1'b1;
    wait_clks(2 * CPB);
  endtask

  task automatic send_word(input logic [15:0] addr, input logic [15:0] data, input bit last = 1'b0);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.last = last;
    sb_q.push_back(e);
    send_byte(data[15:8]);
    send_byte(data[7:0]);
  endtask

  task automatic start_session();
    load_en = 1'b0;
    wait_clks(3);
    load_en   = 1'b1;
    sum_model = '0;
    wait_clks(3);
  endtask

  function automatic logic [15:0] exp_checksum();
`ifdef LOADER_CHECKSUM_EN
    return sum_model;
`else
    return 16'h0000;
`endif
  endfunction

  // Write monitor: every mem_we must match the oldest expected write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk_100);
      if (mem_we === 1'b1) begin
        check("we_while_loading", loading, 1);
        if (sb_q.size() == 0) begin
          check("unexpected_we", mem_we, 0);
        end else begin
          e = sb_q.pop_front();
          check("wr_addr", mem_addr, e.addr);
          check("wr_data", mem_wdata, e.data);
          sum_model = sum_model + e.data;
          if (e.last) begin
            @(negedge clk_100);
            check("done_after_last", done, 1);
            check("loading_after_last", loading, 0);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with rx toggling
    for (int i = 0; i < 6; i++) begin
      rx = ~rx;
      wait_clks(1);
    end
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_loading", loading, 0);
    check("rst_done", done, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_cks", checksum, 0);
    rx = 1'b1;
    wait_clks(2);
    rst = 1'b1;
    wait_clks(4);
    check("post_rst_we", mem_we, 0);
    check("post_rst_loading", loading, 0);

    // Bytes outside a session are ignored
    send_byte(8'h11);
    send_byte(8'h22);
    check("idle_loading", loading, 0);

    // Basic words
    start_session();
    check("sess_loading", loading, 1);
    send_word(16'h0000, 16'h1234);
    send_word(16'h0001, 16'hABCD);
    check("basic_sb_empty", sb_q.size(), 0);
    check("basic_addr", mem_addr, 16'h0002);
    check("basic_cks", checksum, exp_checksum());

    // Full image plus trailing bytes
    start_session();
    check("full_addr0", mem_addr, 0);
    send_word(16'h0000, 16'h0102);
    send_word(16'h0001, 16'h8003);
    send_word(16'h0002, 16'hC3A5);
    send_word(16'h0003, 16'h7F10, 1'b1);
    send_byte(8'hFF);
    send_byte(8'hFF);
    check("full_sb_empty", sb_q.size(), 0);
    check("full_done", done, 1);
    check("full_loading", loading, 0);
    check("full_addr_hold", mem_addr, 16'h0003);
    check("full_cks", checksum, exp_checksum());

    // Framing error
    start_session();
    check("fe_done_clr", done, 0);
    check("fe_clr", frame_err, 0);
    send_byte(8'h55, 1'b0);
    check("fe_set", frame_err, 1);
    send_word(16'h0000, 16'hAA01);
    check("fe_sb_empty", sb_q.size(), 0);
    check("fe_sticky", frame_err, 1);

    // Abort with pending half-word, then restart
    start_session();
    send_byte(8'h66, 1'b0);
    send_byte(8'h77);
    load_en = 1'b0;
    wait_clks(3);
    check("abort_loading", loading, 0);
    check("abort_done", done, 0);
    check("abort_ferr_hold", frame_err, 1);
    wait_clks(CPB);
    load_en   = 1'b1;
    sum_model = '0;
    wait_clks(3);
    check("restart_ferr", frame_err, 0);
    check("restart_loading", loading, 1);
    check("restart_addr", mem_addr, 0);
    send_word(16'h0000, 16'hBEEF);
    check("restart_sb_empty", sb_q.size(), 0);

    // Checksum wrap
    start_session();
    send_word(16'h0000, 16'hFFFF);
    send_word(16'h0001, 16'h0002);
    check("cks_sb_empty", sb_q.size(), 0);
`ifdef LOADER_CHECKSUM_EN
    check("cks_wrap", checksum, 16'h0001);
`else
    check("cks_tied", checksum, 16'h0000);
`endif
    check("cks_addr", mem_addr, 16'h0002);

    wait_clks(5);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
